// File: rtl/text_renderer_if.sv
// Signal bundle between the VGA / keyboard logic and the text renderer.
// master = surrounding lab logic, slave = text_renderer.
interface text_renderer_if #(
    parameter int AW = 6
);
    logic [9:0]    hc;
    logic [9:0]    vc;
    logic          video_on;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          clr;
    logic          busy;
    logic [7:0]    char_sel;
    logic [39:0]   vec_char;
    logic [11:0]   rgb;

    modport master (
        output hc, vc, video_on, wr_en, wr_addr, wr_data, clr, vec_char,
        input  busy, char_sel, rgb
    );

    modport slave (
        input  hc, vc, video_on, wr_en, wr_addr, wr_data, clr, vec_char,
        output busy, char_sel, rgb
    );
endinterface

// File: rtl/text_renderer.sv
// Pixel-stage text overlay: character buffer + 2-stage pixel pipeline.
// Stage 1 maps the sync counters to a buffer cell and glyph row/column and
// presents char_sel to the external glyph ROM; stage 2 turns the returned
// 5x8 bitmap into a registered RGB pixel.
module text_renderer #(
    parameter int          COLS       = 16,
    parameter int          ROWS       = 4,
    parameter int          AW         = 6,
    parameter int          X0         = 64,
    parameter int          Y0         = 32,
    parameter int          SCALE_LOG2 = 1,
    parameter logic [11:0] FG_COLOR   = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h00F
) (
    input  logic           clk,
    input  logic           rst,
    text_renderer_if.slave bus
);
    localparam int N     = COLS * ROWS;
    localparam int SH    = 3 + SCALE_LOG2;
    localparam int W_PIX = COLS << SH;
    localparam int H_PIX = ROWS << SH;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [9:0] X0_V = 10'(X0);
    localparam logic [9:0] Y0_V = 10'(Y0);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state;
    logic          busy_q;
    logic [AW-1:0] clr_idx;
    logic [7:0]    buffer [N];

    // Clear sequencer: walks every cell once; reset lands in CLEAR so the
    // buffer is blanked automatically and a reset mid-clear restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            busy_q  <= 1'b1;
            clr_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr) begin
                        state   <= CLEAR;
                        busy_q  <= 1'b1;
                        clr_idx <= '0;
                    end
                end
                CLEAR: begin
                    if (int'(clr_idx) == N - 1) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;

    // Buffer write port: the clear owns it while busy, host writes otherwise.
    always_ff @(posedge clk) begin
        if (!rst && state == CLEAR)
            buffer[clr_idx] <= 8'd32;
        else if (!rst && state == IDLE && bus.wr_en && int'(bus.wr_addr) < N)
            buffer[bus.wr_addr] <= bus.wr_data;
    end

    // Stage-1 inputs: offsets wrap harmlessly outside the region since
    // in_region masks everything downstream.
    logic [9:0] dx, dy;
    logic       in_region;

    always_comb begin
        dx        = bus.hc - X0_V;
        dy        = bus.vc - Y0_V;
        in_region = bus.video_on
                 && int'(bus.hc) >= X0 && int'(bus.hc) < X0 + W_PIX
                 && int'(bus.vc) >= Y0 && int'(bus.vc) < Y0 + H_PIX;
    end

    logic          s1_vld;
    logic          in_q, von_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [2:0]    gx_q, gy_q;

    // Stage 1 registers: cell coordinates and glyph row/column.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            in_q   <= 1'b0;
            von_q  <= 1'b0;
            col_q  <= '0;
            row_q  <= '0;
            gx_q   <= '0;
            gy_q   <= '0;
        end else begin
            s1_vld <= 1'b1;
            in_q   <= in_region;
            von_q  <= bus.video_on;
            col_q  <= CW'(dx >> SH);
            row_q  <= RW'(dy >> SH);
            gx_q   <= 3'(dx >> SCALE_LOG2);
            gy_q   <= 3'(dy >> SCALE_LOG2);
        end
    end

    // Buffer read is asynchronous so the glyph ROM sees char_sel in the same
    // cycle and stage 2 can consume vec_char directly.
    logic [AW-1:0] rd_addr;
    assign rd_addr      = AW'(int'(row_q) * COLS + int'(col_q));
    assign bus.char_sel = in_q ? buffer[rd_addr] : 8'd32;

    // Columns 5..7 of each cell are inter-character spacing.
    logic [5:0] bit_idx;
    logic       glyph_bit;
    assign bit_idx   = 6'(5 * int'(gy_q) + int'(gx_q));
    assign glyph_bit = (gx_q < 3'd5) ? bus.vec_char[bit_idx] : 1'b0;

    logic [11:0] rgb_q;

    // Stage 2: colour select, black outside the region or blanking.
    always_ff @(posedge clk) begin
        if (rst)
            rgb_q <= '0;
        else if (!s1_vld || !von_q)
            rgb_q <= '0;
        else if (in_q && glyph_bit)
            rgb_q <= FG_COLOR;
        else if (in_q)
            rgb_q <= BG_COLOR;
        else
            rgb_q <= '0;
    end

    assign bus.rgb = rgb_q;
endmodule

// File: doc/text_renderer.md
Name: text_renderer

Overview:
- Pixel-stage text overlay for the PS2/VGA lab.
- Holds a ROWS x COLS character buffer, written by the keyboard/ASCII logic.
- Converts the VGA sync counters into a buffer address plus glyph row/column, and drives char_sel to the combinational glyph lookup.
- Takes the returned 40-bit 5x8 bitmap and outputs a registered 12-bit RGB pixel, 2-cycle latency.

Parameters:
- COLS, 16, characters per text row.
- ROWS, 4, text rows.
- AW, 6, buffer address width; COLS*ROWS <= 2^AW.
- X0, 64, left pixel x of the text region.
- Y0, 32, top pixel y of the text region.
- SCALE_LOG2, 1, pixel magnification = 2^SCALE_LOG2; cell = (8<<S) x (8<<S) pixels.
- FG_COLOR, 12'hFFF, RGB for lit glyph pixels.
- BG_COLOR, 12'h00F, RGB inside the region for unlit pixels.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hc  in  10  VGA horizontal counter
- vc  in  10  VGA vertical counter
- video_on  in  1  high in the visible area
- wr_en  in  1  write strobe for the character buffer
- wr_addr  in  AW  buffer index = row*COLS + col
- wr_data  in  8  ASCII code
- clr  in  1  single-cycle request to fill the buffer with spaces
- busy  out  1  clear in progress; writes and clr are ignored while high
- char_sel  out  8  ASCII code to the glyph lookup (combinational from stage-1 registers)
- vec_char  in  40  glyph bitmap from the lookup; row r (0 = top) = bits [5r+4:5r]; column c (0 = left) = bit 5r+c
- rgb  out  12  registered pixel colour

Behaviour:
- Reset (rst high at a clk edge):
  - rgb=0; stage-1 and stage-2 valid flags cleared.
  - busy=1; clear index = 0.
  - After rst falls, clear runs automatically.
  - rst asserted mid-clear restarts the clear from index 0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr=1 (only sampled in IDLE).
  - CLEAR writes 8'd32 to index i, one entry per cycle, i = 0..COLS*ROWS-1.
  - Returns to IDLE the cycle after the last write.
  - busy = (state==CLEAR); a clear takes exactly COLS*ROWS cycles.
- Writes:
  - When wr_en=1, busy=0 and wr_addr < COLS*ROWS: buffer[wr_addr] <= wr_data.
  - Otherwise the write is dropped.
  - A write takes effect at the edge; a same-cycle read sees the old value.
- Stage 1 (edge 1), registered from hc/vc:
  - dx = hc - X0, dy = vc - Y0, 10-bit unsigned.
  - in_region = video_on && hc >= X0 && hc < X0 + (COLS<<(3+S)) && vc >= Y0 && vc < Y0 + (ROWS<<(3+S)).
  - Registers: col_idx = dx>>(3+S), row_idx = dy>>(3+S), gx = (dx>>S)[2:0], gy = (dy>>S)[2:0], in_region, video_on.
  - char_sel = buffer[row_idx*COLS + col_idx]; it is 8'd32 when in_region=0.
- Stage 2 (edge 2):
  - lit = in_region_q && gx_q < 5 && vec_char[5*gy_q + gx_q].
  - rgb <= !video_on_q ? 0 : lit ? FG_COLOR : (in_region_q ? BG_COLOR : 0).
  - Glyph columns 5..7 are inter-character spacing and always unlit.
- Latency: hc/vc presented in cycle n -> rgb valid after edge n+2. The sync generator must delay hsync/vsync by 2 to match.
- Pipeline runs every cycle and is unaffected by busy, so a clear shows partially cleared text on screen.

Test Plan:
- Reset then clear: hold rst 3 cycles, release -> busy=1 for exactly 64 cycles, then 0. Reading every index through char_sel returns 8'd32.
- Single glyph, S=1, X0=64, Y0=32: write 8'h31 at addr 0; stub vec_char=40'h000000001F when char_sel=8'h31.
  - (hc=64..73, vc=32..33) -> rgb=12'hFFF two cycles later.
  - hc=74..79 -> 12'h00F.
  - vc=34 -> 12'h00F.
- Addressing: write 8'h41 at addr 17; hc=64+16, vc=32+16 -> char_sel=8'h41 one edge after.
- Region edges: hc=63 and hc=64+256 -> rgb=0. video_on=0 inside the region -> rgb=0.
- Busy interlock: pulse clr, then wr_en at addr 5 with 8'h62 during busy -> write dropped, buffer[5]=32. The same write after busy falls -> stored.
- Mid-clear reset: assert rst at clear cycle 20 -> busy stays 1, clear restarts, busy falls 64 cycles after rst release. Out-of-range wr_addr=63 with 64 entries is valid; with ROWS=3 it is dropped.
